// File: rtl/mem_chk_pkg.sv
// rtl/mem_chk_pkg.sv - checkpoint codes, FSM state and phase encodings for the SRAM test monitor
// Contents: nine firmware checkpoint codes, state_t, phase_t, classification helpers.
package mem_chk_pkg;

    localparam logic [15:0] CODE_WORD_START  = 16'hA040;
    localparam logic [15:0] CODE_WORD_FAIL   = 16'hAB40;
    localparam logic [15:0] CODE_WORD_PASS   = 16'hAB41;
    localparam logic [15:0] CODE_SHORT_START = 16'hA020;
    localparam logic [15:0] CODE_SHORT_FAIL  = 16'hAB20;
    localparam logic [15:0] CODE_SHORT_PASS  = 16'hAB21;
    localparam logic [15:0] CODE_BYTE_START  = 16'hA010;
    localparam logic [15:0] CODE_BYTE_FAIL   = 16'hAB10;
    localparam logic [15:0] CODE_BYTE_PASS   = 16'hAB11;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WORD, ST_WORD_OK, ST_SHORT, ST_SHORT_OK, ST_BYTE,
        ST_PASS, ST_FAIL, ST_TIMEOUT
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_WORD  = 2'd1,
        PH_SHORT = 2'd2,
        PH_BYTE  = 2'd3
    } phase_t;

    function automatic logic is_recognised(input logic [15:0] code);
        return code inside {CODE_WORD_START, CODE_WORD_FAIL, CODE_WORD_PASS,
                            CODE_SHORT_START, CODE_SHORT_FAIL, CODE_SHORT_PASS,
                            CODE_BYTE_START, CODE_BYTE_FAIL, CODE_BYTE_PASS};
    endfunction

    function automatic logic is_terminal(input state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

    // Only meaningful for non-terminal states; terminal states keep the previous phase.
    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        case (s)
            ST_WORD, ST_WORD_OK:   p = PH_WORD;
            ST_SHORT, ST_SHORT_OK: p = PH_SHORT;
            ST_BYTE:               p = PH_BYTE;
            default:               p = PH_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/checkbits_stable_filter.sv
// rtl/checkbits_stable_filter.sv - debounces the checkpoint code and pulses on each newly stable value
// Ports: core_clk, core_rstn (async active-low), checkbits[15:0] in;
//        accept (one-cycle pulse), accept_code[15:0] (valid with accept) out.
module checkbits_stable_filter #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic [15:0] checkbits,
    output logic        accept,
    output logic [15:0] accept_code
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [15:0]   cand;
    logic [15:0]   last_code;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            cand       <= '0;
            last_code  <= '0;
            stable_cnt <= '0;
        end else begin
            if (checkbits != cand) begin
                cand       <= checkbits;
                stable_cnt <= CW'(1);
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
            // Recording the accepted code drops accept after exactly one cycle
            // and stops a held code from being accepted twice.
            if (accept) begin
                last_code <= cand;
            end
        end
    end

    assign accept      = (stable_cnt == CNT_MAX) && (cand != last_code);
    assign accept_code = cand;

endmodule

// File: rtl/mem_checkpoint_monitor.sv
// rtl/mem_checkpoint_monitor.sv - tracks SRAM word/short/byte checkpoint order with sticky pass/fail/timeout
// Ports: core_clk, core_rstn (async active-low), checkbits[15:0], clear (sync restart) in;
//        phase[1:0], busy, pass, fail, timeout, done, fail_code[15:0],
//        event_valid, event_code[15:0] out.
module mem_checkpoint_monitor
    import mem_chk_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 300000,
    parameter int CNT_W          = 19,
    parameter int STABLE_CYCLES  = 2
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic [15:0] checkbits,
    input  logic        clear,
    output logic [1:0]  phase,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        done,
    output logic [15:0] fail_code,
    output logic        event_valid,
    output logic [15:0] event_code
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             acc;
    logic [15:0]      acc_code;
    logic             known_acc;
    state_t           state;
    state_t           state_nx;
    phase_t           phase_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [15:0]      fail_hold;
    logic             pass_q;
    logic             fail_q;
    logic             timeout_q;

    checkbits_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .core_clk    (core_clk),
        .core_rstn   (core_rstn),
        .checkbits   (checkbits),
        .accept      (acc),
        .accept_code (acc_code)
    );

    assign known_acc = acc && is_recognised(acc_code);

    always_comb begin
        state_nx = state;
        if (known_acc) begin
            unique case (state)
                ST_IDLE:     state_nx = (acc_code == CODE_WORD_START)  ? ST_WORD     : ST_FAIL;
                ST_WORD:     state_nx = (acc_code == CODE_WORD_PASS)   ? ST_WORD_OK  : ST_FAIL;
                ST_WORD_OK:  state_nx = (acc_code == CODE_SHORT_START) ? ST_SHORT    : ST_FAIL;
                ST_SHORT:    state_nx = (acc_code == CODE_SHORT_PASS)  ? ST_SHORT_OK : ST_FAIL;
                ST_SHORT_OK: state_nx = (acc_code == CODE_BYTE_START)  ? ST_BYTE     : ST_FAIL;
                ST_BYTE:     state_nx = (acc_code == CODE_BYTE_PASS)   ? ST_PASS     : ST_FAIL;
                default:     state_nx = state;
            endcase
        end
        // A verdict reached by a code in the last cycle outranks the timeout.
        if (!is_terminal(state) && (tmo_cnt == TMO_LAST) &&
            (state_nx != ST_PASS) && (state_nx != ST_FAIL)) begin
            state_nx = ST_TIMEOUT;
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            tmo_cnt     <= '0;
            phase_q     <= PH_IDLE;
            fail_hold   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code   <= '0;
            event_valid <= 1'b0;
            event_code  <= '0;
        end else if (clear) begin
            tmo_cnt     <= '0;
            phase_q     <= PH_IDLE;
            fail_hold   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code   <= '0;
            event_valid <= 1'b0;
            event_code  <= '0;
        end else begin
            if (!is_terminal(state)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (!is_terminal(state_nx)) begin
                phase_q <= phase_of(state_nx);
            end
            if (!is_terminal(state) && (state_nx == ST_FAIL)) begin
                fail_hold <= acc_code;
            end
            // Status trails the state register by one cycle.
            pass_q      <= (state == ST_PASS);
            fail_q      <= (state == ST_FAIL);
            timeout_q   <= (state == ST_TIMEOUT);
            fail_code   <= (state == ST_FAIL) ? fail_hold : 16'h0000;
            event_valid <= known_acc;
            if (known_acc) begin
                event_code <= acc_code;
            end
        end
    end

    assign phase   = phase_q;
    assign busy    = (state != ST_IDLE) && !is_terminal(state);
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign timeout = timeout_q;
    assign done    = pass_q | fail_q | timeout_q;

endmodule

// File: tb/tb_mem_checkpoint_monitor.sv
// tb/tb_mem_checkpoint_monitor.sv - directed self-checking bench for mem_checkpoint_monitor
module tb_mem_checkpoint_monitor;

    logic        core_clk;
    logic        core_rstn;
    logic [15:0] checkbits;
    logic        clear;
    logic [1:0]  phase;
    logic        busy;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        done;
    logic [15:0] fail_code;
    logic        event_valid;
    logic [15:0] event_code;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_cnt  = 0;

    mem_checkpoint_monitor #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (8),
        .STABLE_CYCLES  (2)
    ) dut (
        .core_clk    (core_clk),
        .core_rstn   (core_rstn),
        .checkbits   (checkbits),
        .clear       (clear),
        .phase       (phase),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .done        (done),
        .fail_code   (fail_code),
        .event_valid (event_valid),
        .event_code  (event_code)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything after this runs 1 time unit past the edge.
    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic hold(input logic [15:0] code, input int n);
        checkbits = code;
        for (int i = 0; i < n; i++) begin
            tick();
            if (event_valid) ev_cnt++;
        end
    endtask

    task automatic do_reset();
        core_rstn = 1'b0;
        clear     = 1'b0;
        checkbits = 16'h0000;
        tick();
        tick();
        core_rstn = 1'b1;
        ev_cnt    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_phase",   16'(phase), 16'd0);
        check("rst_busy",    16'(busy), 16'd0);
        check("rst_done",    16'(done), 16'd0);
        check("rst_failcd",  fail_code, 16'h0000);
        check("rst_evcode",  event_code, 16'h0000);
        check("rst_evvalid", 16'(event_valid), 16'd0);

        // Nominal run
        hold(16'hA040, 10); check("nom_ph_w",  16'(phase), 16'd1);
        check("nom_busy", 16'(busy), 16'd1);
        hold(16'hAB41, 10); check("nom_ph_wok", 16'(phase), 16'd1);
        hold(16'hA020, 10); check("nom_ph_s",  16'(phase), 16'd2);
        hold(16'hAB21, 10); check("nom_ph_sok", 16'(phase), 16'd2);
        hold(16'hA010, 10); check("nom_ph_b",  16'(phase), 16'd3);
        hold(16'hAB11, 10);
        check("nom_events", 16'(ev_cnt), 16'd6);
        check("nom_pass",   16'(pass), 16'd1);
        check("nom_done",   16'(done), 16'd1);
        check("nom_fail",   16'(fail), 16'd0);
        check("nom_failcd", fail_code, 16'h0000);
        check("nom_phase",  16'(phase), 16'd3);
        check("nom_busy2",  16'(busy), 16'd0);
        check("nom_evcode", event_code, 16'hAB11);

        // Word fail, then a sticky terminal state
        do_reset();
        hold(16'hA040, 10);
        hold(16'hAB40, 10);
        check("wf_fail",   16'(fail), 16'd1);
        check("wf_failcd", fail_code, 16'hAB40);
        check("wf_phase",  16'(phase), 16'd1);
        check("wf_pass",   16'(pass), 16'd0);
        ev_cnt = 0;
        hold(16'hAB11, 10);
        check("wf_late_ev",   16'(ev_cnt), 16'd1);
        check("wf_late_code", event_code, 16'hAB11);
        check("wf_late_fail", 16'(fail), 16'd1);
        check("wf_late_pass", 16'(pass), 16'd0);
        check("wf_late_fcd",  fail_code, 16'hAB40);

        // Glitch rejection and acceptance latency
        do_reset();
        checkbits = 16'hA040;
        tick();
        hold(16'h0000, 6);
        check("gl_events", 16'(ev_cnt), 16'd0);
        check("gl_phase",  16'(phase), 16'd0);
        check("gl_busy",   16'(busy), 16'd0);
        checkbits = 16'hA040;
        tick();
        tick();
        check("gl_lat2_phase", 16'(phase), 16'd0);
        tick();
        check("gl_lat3_phase", 16'(phase), 16'd1);
        check("gl_lat3_ev",    16'(event_valid), 16'd1);
        tick();
        check("gl_pulse_end",  16'(event_valid), 16'd0);

        // Unknown code ignored, then an order violation
        do_reset();
        hold(16'hA040, 10);
        hold(16'hAB41, 10);
        ev_cnt = 0;
        hold(16'h1234, 10);
        check("ov_unk_ev",   16'(ev_cnt), 16'd0);
        check("ov_unk_busy", 16'(busy), 16'd1);
        check("ov_unk_fail", 16'(fail), 16'd0);
        hold(16'hA010, 10);
        check("ov_fail",   16'(fail), 16'd1);
        check("ov_failcd", fail_code, 16'hA010);
        check("ov_phase",  16'(phase), 16'd1);

        // Timeout: counter hits 99 after edge 99, state goes TIMEOUT at edge 100,
        // status follows at edge 101.
        do_reset();
        checkbits = 16'hA040;
        for (int i = 0; i < 99; i++) tick();
        check("to_e99_tmo",  16'(timeout), 16'd0);
        check("to_e99_busy", 16'(busy), 16'd1);
        tick();
        check("to_e100_busy", 16'(busy), 16'd0);
        tick();
        check("to_tmo",  16'(timeout), 16'd1);
        check("to_done", 16'(done), 16'd1);
        check("to_fail", 16'(fail), 16'd0);
        check("to_busy", 16'(busy), 16'd0);

        // Fail accepted in the last cycle beats the timeout
        do_reset();
        checkbits = 16'hA040;
        for (int i = 0; i < 97; i++) tick();
        checkbits = 16'hAB40;
        for (int i = 0; i < 4; i++) tick();
        check("tr_fail",   16'(fail), 16'd1);
        check("tr_tmo",    16'(timeout), 16'd0);
        check("tr_failcd", fail_code, 16'hAB40);
        hold(16'hAB40, 5);
        check("tr_tmo_late", 16'(timeout), 16'd0);

        // Clear in BYTE
        do_reset();
        hold(16'hA040, 10);
        hold(16'hAB41, 10);
        hold(16'hA020, 10);
        hold(16'hAB21, 10);
        hold(16'hA010, 10);
        check("cl_pre_phase", 16'(phase), 16'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("cl_phase",  16'(phase), 16'd0);
        check("cl_busy",   16'(busy), 16'd0);
        check("cl_done",   16'(done), 16'd0);
        check("cl_evcode", event_code, 16'h0000);
        check("cl_failcd", fail_code, 16'h0000);
        ev_cnt = 0;
        hold(16'hA010, 10);
        check("cl_noreacc_ev", 16'(ev_cnt), 16'd0);
        check("cl_noreacc_ph", 16'(phase), 16'd0);

        // Asynchronous reset mid-SHORT
        do_reset();
        hold(16'hA040, 10);
        hold(16'hAB41, 10);
        hold(16'hA020, 10);
        check("ar_pre_phase", 16'(phase), 16'd2);
        check("ar_pre_code",  event_code, 16'hA020);
        #2;
        core_rstn = 1'b0;
        #1;
        check("ar_phase",  16'(phase), 16'd0);
        check("ar_busy",   16'(busy), 16'd0);
        check("ar_evcode", event_code, 16'h0000);
        check("ar_done",   16'(done), 16'd0);
        tick();
        core_rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
